// File: rtl/descriptor_normalize_pkg.sv
// Shared SIFT descriptor parameters, FSM encoding and the output saturation helper.
package descriptor_normalize_pkg;

  localparam int DESC_SIZE   = 128;
  localparam int ELEM_BITS   = 13;
  localparam int SUM_BITS    = 20;
  localparam int SCALE_SHIFT = 9;
  localparam int OUT_BITS    = 8;

  localparam int IDX_BITS    = $clog2(DESC_SIZE);
  localparam int NUM_BITS    = ELEM_BITS + SCALE_SHIFT;
  // elem <= sum bounds the quotient to 2^SCALE_SHIFT, so one extra bit suffices
  localparam int QUOT_BITS   = SCALE_SHIFT + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SUM = 2'd1,
    ST_DIV      = 2'd2,
    ST_OUT      = 2'd3
  } state_t;

  // Clamp a quotient to the largest value representable in OUT_BITS
  function automatic logic [OUT_BITS-1:0] saturate_q(input logic [QUOT_BITS-1:0] q);
    if (q > QUOT_BITS'((1 << OUT_BITS) - 1)) begin
      return '1;
    end
    return q[OUT_BITS-1:0];
  endfunction

endpackage

// File: rtl/descriptor_normalize_seq_udiv.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Timing: istart cycle loads, Q_W iterate cycles, then one cycle with odone=1
// while oquot holds the result. The caller guarantees inum >> Q_W < iden so
// the quotient fits in Q_W bits; the partial remainder starts from those
// upper numerator bits and the low Q_W bits are shifted in one per step.
module seq_udiv #(
  parameter int NUM_W = 22,
  parameter int DEN_W = 20,
  parameter int Q_W   = 10
) (
  input  logic             iclk,
  input  logic             ireset,
  input  logic             istart,
  input  logic [NUM_W-1:0] inum,
  input  logic [DEN_W-1:0] iden,
  output logic             obusy,
  output logic             odone,
  output logic [Q_W-1:0]   oquot
);

  localparam int CNT_W = $clog2(Q_W + 1);

  logic [DEN_W-1:0] r_rem;
  logic [DEN_W-1:0] r_den;
  logic [Q_W-1:0]   r_num_lo;
  logic [Q_W-1:0]   r_quot;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  logic [DEN_W:0]   w_shifted;
  logic [DEN_W-1:0] w_diff;
  logic             w_ge;

  // Trial subtraction of the divisor from the shifted partial remainder
  assign w_shifted = {r_rem, r_num_lo[Q_W-1]};
  assign w_ge      = (w_shifted >= {1'b0, r_den});
  assign w_diff    = w_shifted[DEN_W-1:0] - r_den;

  assign obusy = r_busy;
  assign odone = r_busy && (r_cnt == CNT_W'(Q_W));
  assign oquot = r_quot;

  // Load on start, iterate Q_W times, then drop busy after the done cycle
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_rem    <= '0;
      r_den    <= '0;
      r_num_lo <= '0;
      r_quot   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (istart && !r_busy) begin
      r_rem    <= DEN_W'(inum[NUM_W-1:Q_W]);
      r_num_lo <= inum[Q_W-1:0];
      r_den    <= iden;
      r_quot   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      if (odone) begin
        r_busy <= 1'b0;
      end else begin
        r_rem    <= w_ge ? w_diff : w_shifted[DEN_W-1:0];
        r_num_lo <= r_num_lo << 1;
        r_quot   <= {r_quot[Q_W-2:0], w_ge};
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/descriptor_normalize.sv
// Captures a SIFT descriptor, waits for its L1 sum, then streams each element
// normalised to min(255, (elem << SCALE_SHIFT) / sum) one at a time.
//
// Output handshake: an element transfers on a rising edge where odval=1 and
// iready=1. While odval=1 and iready=0, odata/oidx/olast are held stable.
// Input side: idval is honoured only while oready=1; otherwise it is dropped.
module descriptor_normalize
  import descriptor_normalize_pkg::*;
(
  input  logic                           iclk,
  input  logic                           ireset,
  input  logic                           idval,
  input  logic [DESC_SIZE*ELEM_BITS-1:0] idata,
  input  logic                           isum_dval,
  input  logic [SUM_BITS-1:0]            isum,
  output logic                           oready,
  output logic                           odval,
  output logic [OUT_BITS-1:0]            odata,
  output logic [IDX_BITS-1:0]            oidx,
  output logic                           olast,
  input  logic                           iready,
  output logic [1:0]                     odbg_state
);

  state_t                r_state;
  state_t                w_next_state;

  logic [ELEM_BITS-1:0]  r_vec [DESC_SIZE];
  logic [SUM_BITS-1:0]   r_sum;
  logic [IDX_BITS-1:0]   r_idx;
  logic                  r_ready;
  logic                  r_odval;
  logic [OUT_BITS-1:0]   r_odata;
  logic [IDX_BITS-1:0]   r_oidx;
  logic                  r_olast;

  logic                  w_capture;
  logic                  w_sum_take;
  logic                  w_sum_zero;
  logic                  w_res_valid;
  logic                  w_handshake;
  logic                  w_last_idx;
  logic [ELEM_BITS-1:0]  w_elem;
  logic [NUM_BITS-1:0]   w_num;
  logic                  w_div_start;
  logic                  w_div_busy;
  logic                  w_div_done;
  logic [QUOT_BITS-1:0]  w_div_quot;
  logic [OUT_BITS-1:0]   w_q_sat;

  assign w_capture   = (r_state == ST_IDLE) && idval;
  assign w_sum_take  = (r_state == ST_WAIT_SUM) && isum_dval;
  assign w_sum_zero  = (r_sum == '0);
  // A zero sum bypasses the divider and yields 0 in a single DIV cycle
  assign w_res_valid = (r_state == ST_DIV) && (w_sum_zero || w_div_done);
  assign w_handshake = (r_state == ST_OUT) && iready;
  assign w_last_idx  = (r_idx == IDX_BITS'(DESC_SIZE - 1));

  assign w_elem      = r_vec[r_idx];
  assign w_num       = {w_elem, {SCALE_SHIFT{1'b0}}};
  // First DIV cycle of each element: divider idle, so kick it off
  assign w_div_start = (r_state == ST_DIV) && !w_div_busy && !w_sum_zero;
  assign w_q_sat     = w_sum_zero ? '0 : saturate_q(w_div_quot);

  seq_udiv #(
    .NUM_W (NUM_BITS),
    .DEN_W (SUM_BITS),
    .Q_W   (QUOT_BITS)
  ) u_div (
    .iclk   (iclk),
    .ireset (ireset),
    .istart (w_div_start),
    .inum   (w_num),
    .iden   (r_sum),
    .obusy  (w_div_busy),
    .odone  (w_div_done),
    .oquot  (w_div_quot)
  );

  // State register
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:     if (w_capture)   w_next_state = ST_WAIT_SUM;
      ST_WAIT_SUM: if (w_sum_take)  w_next_state = ST_DIV;
      ST_DIV:      if (w_res_valid) w_next_state = ST_OUT;
      ST_OUT:      if (w_handshake) w_next_state = w_last_idx ? ST_IDLE : ST_DIV;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  // Descriptor vector capture; contents are don't-care until the next capture
  always_ff @(posedge iclk) begin
    if (w_capture) begin
      for (int i = 0; i < DESC_SIZE; i++) begin
        r_vec[i] <= idata[i*ELEM_BITS +: ELEM_BITS];
      end
    end
  end

  // Sum, index counter and registered output stage
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_ready <= 1'b1;
      r_sum   <= '0;
      r_idx   <= '0;
      r_odval <= 1'b0;
      r_odata <= '0;
      r_oidx  <= '0;
      r_olast <= 1'b0;
    end else begin
      if (w_capture) begin
        r_ready <= 1'b0;
      end
      if (w_sum_take) begin
        r_sum <= isum;
        r_idx <= '0;
      end
      if (w_res_valid) begin
        r_odval <= 1'b1;
        r_odata <= w_q_sat;
        r_oidx  <= r_idx;
        r_olast <= w_last_idx;
      end
      if (w_handshake) begin
        r_odval <= 1'b0;
        r_olast <= 1'b0;
        if (w_last_idx) begin
          r_ready <= 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign oready     = r_ready;
  assign odval      = r_odval;
  assign odata      = r_odata;
  assign oidx       = r_oidx;
  assign olast      = r_olast;
  assign odbg_state = r_state;

endmodule

// File: tb/tb_descriptor_normalize.sv
// Self-checking bench for descriptor_normalize: scoreboard of expected
// {olast, oidx, odata} entries, popped on each output handshake.
module tb_descriptor_normalize;
  import descriptor_normalize_pkg::*;

  localparam int DW = DESC_SIZE * ELEM_BITS;

  // ---------------- clock / reset ----------------
  logic                 iclk = 1'b0;
  logic                 ireset;
  logic                 idval;
  logic [DW-1:0]        idata;
  logic                 isum_dval;
  logic [SUM_BITS-1:0]  isum;
  logic                 oready;
  logic                 odval;
  logic [OUT_BITS-1:0]  odata;
  logic [IDX_BITS-1:0]  oidx;
  logic                 olast;
  logic                 iready;
  logic [1:0]           odbg_state;

  always #5 iclk = ~iclk;

  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  descriptor_normalize dut (
    .iclk       (iclk),
    .ireset     (ireset),
    .idval      (idval),
    .idata      (idata),
    .isum_dval  (isum_dval),
    .isum       (isum),
    .oready     (oready),
    .odval      (odval),
    .odata      (odata),
    .oidx       (oidx),
    .olast      (olast),
    .iready     (iready),
    .odbg_state (odbg_state)
  );

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [15:0]   exp_q[$];
  logic [15:0]   mon_e;
  int            exp_gap;
  int            exp_lat;
  int            sum_cyc;
  int            last_hs_cyc;
  logic          first_hs;
  logic          hold_vld;
  logic [OUT_BITS-1:0] hold_data;
  logic [IDX_BITS-1:0] hold_idx;
  logic          hold_last;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference normalisation: floor((elem * 2^SCALE_SHIFT) / sum), clamp 255, 0 if sum==0
  function automatic logic [7:0] norm_ref(input int elem, input int sum);
    int q;
    if (sum == 0) return 8'd0;
    q = (elem * (1 << SCALE_SHIFT)) / sum;
    if (q > 255) return 8'd255;
    return 8'(q);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge iclk) begin
    if (!ireset && hold_vld) begin
      check_val("hold_odval", 32'(odval), 32'd1);
      check_val("hold_odata", 32'(odata), 32'(hold_data));
      check_val("hold_oidx",  32'(oidx),  32'(hold_idx));
      check_val("hold_olast", 32'(olast), 32'(hold_last));
    end
    hold_vld  = !ireset && odval && !iready;
    hold_data = odata;
    hold_idx  = oidx;
    hold_last = olast;

    if (!ireset && odval && iready) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_output_idx", 32'(oidx), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("odata", 32'(odata), 32'(mon_e[7:0]));
        check_val("oidx",  32'(oidx),  32'(mon_e[14:8]));
        check_val("olast", 32'(olast), 32'(mon_e[15]));
        if (first_hs) begin
          check_val("first_latency", 32'(cyc - sum_cyc), 32'(exp_lat));
          first_hs = 1'b0;
        end else if (exp_gap > 0) begin
          check_val("elem_gap", 32'(cyc - last_hs_cyc), 32'(exp_gap));
        end
        if (mon_e[15] && exp_gap == 13) begin
          check_val("desc_latency", 32'(cyc - sum_cyc), 32'd1663);
        end
        last_hs_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_desc(input logic [DW-1:0] d, input logic [SUM_BITS-1:0] s,
                            input int gap, input logic bogus_sum);
    logic [7:0] q;
    for (int i = 0; i < DESC_SIZE; i++) begin
      q = norm_ref(int'(d[i*ELEM_BITS +: ELEM_BITS]), int'(s));
      exp_q.push_back({(i == DESC_SIZE - 1), 7'(i), q});
    end
    exp_gap  = gap;
    exp_lat  = (s == '0) ? 1 : 12;
    first_hs = 1'b1;
    @(posedge iclk); #1;
    idata = d;
    idval = 1'b1;
    if (bogus_sum) begin
      isum      = ~s;
      isum_dval = 1'b1;
    end
    @(posedge iclk); #1;
    idval     = 1'b0;
    isum_dval = 1'b0;
    repeat (3) @(posedge iclk);
    #1;
    isum      = s;
    isum_dval = 1'b1;
    sum_cyc   = cyc + 1;
    @(posedge iclk); #1;
    isum_dval = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge iclk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check_val("timeout_remaining", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge iclk);
    check_val("oready_after_last", 32'(oready), 32'd1);
    check_val("odval_after_last",  32'(odval),  32'd0);
    check_val("state_after_last",  32'(odbg_state), 32'(ST_IDLE));
  endtask

  task automatic rand_desc(output logic [DW-1:0] d, output logic [SUM_BITS-1:0] s);
    int acc = 0;
    int e;
    d = '0;
    for (int i = 0; i < DESC_SIZE; i++) begin
      e = int'($urandom_range(0, 8191));
      d[i*ELEM_BITS +: ELEM_BITS] = ELEM_BITS'(e);
      acc += e;
    end
    s = SUM_BITS'(acc);
  endtask

  // ---------------- main sequence ----------------
  logic [DW-1:0]       d;
  logic [SUM_BITS-1:0] s;
  logic [7:0]          q10;
  int                  st_n;
  logic                st_got;

  initial begin
    ireset = 1'b1; idval = 1'b0; isum_dval = 1'b0; isum = '0; idata = '0; iready = 1'b1;
    exp_gap = 0; exp_lat = 0; sum_cyc = 0; last_hs_cyc = 0; first_hs = 1'b0; hold_vld = 1'b0;
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    check_val("rst_oready", 32'(oready), 32'd1);
    check_val("rst_odval",  32'(odval),  32'd0);
    check_val("rst_odata",  32'(odata),  32'd0);
    check_val("rst_oidx",   32'(oidx),   32'd0);
    check_val("rst_olast",  32'(olast),  32'd0);
    check_val("rst_state",  32'(odbg_state), 32'(ST_IDLE));
    @(posedge iclk); #1;
    ireset = 1'b0;

    // All ones, sum 128 -> every element 4
    d = '0;
    for (int i = 0; i < DESC_SIZE; i++) d[i*ELEM_BITS +: ELEM_BITS] = 13'd1;
    start_desc(d, 20'd128, 13, 1'b0);
    wait_done(3000);

    // Single element equal to the sum -> 512 saturates to 255
    d = '0;
    d[5*ELEM_BITS +: ELEM_BITS] = 13'd100;
    start_desc(d, 20'd100, 13, 1'b0);
    wait_done(3000);

    // 3000/1000 of 4000 -> 255 (384 saturated) and 128; bogus sum alongside idval
    d = '0;
    d[0*ELEM_BITS +: ELEM_BITS] = 13'd3000;
    d[1*ELEM_BITS +: ELEM_BITS] = 13'd1000;
    start_desc(d, 20'd4000, 13, 1'b1);
    wait_done(3000);

    // Zero sum with nonzero elements -> all zero, two-cycle element spacing
    rand_desc(d, s);
    d[0 +: ELEM_BITS] = 13'd77;
    start_desc(d, 20'd0, 2, 1'b0);
    wait_done(600);

    // Back-pressure at oidx 10 for 20 cycles plus a rogue idval
    rand_desc(d, s);
    q10 = norm_ref(int'(d[10*ELEM_BITS +: ELEM_BITS]), int'(s));
    fork
      start_desc(d, s, 0, 1'b0);
      begin
        st_got = 1'b0; st_n = 0;
        while (!st_got && st_n < 3000) begin
          @(negedge iclk); st_n++;
          if (odval && oidx == 7'd9) st_got = 1'b1;
        end
        check_val("stall_reach_idx9", 32'(st_got), 32'd1);
        @(posedge iclk); #1;
        iready = 1'b0;
        st_got = 1'b0; st_n = 0;
        while (!st_got && st_n < 100) begin
          @(negedge iclk); st_n++;
          if (odval && oidx == 7'd10) st_got = 1'b1;
        end
        check_val("stall_reach_idx10", 32'(st_got), 32'd1);
        for (int k = 0; k < 20; k++) begin
          @(posedge iclk); #1;
          idval = (k == 3);
          if (k == 3) idata = ~d;
          @(negedge iclk);
          check_val("stall_odata",  32'(odata),  32'(q10));
          check_val("stall_oready", 32'(oready), 32'd0);
        end
        @(posedge iclk); #1;
        idval  = 1'b0;
        iready = 1'b1;
      end
    join
    wait_done(3000);

    // Reset in the middle of a descriptor
    rand_desc(d, s);
    start_desc(d, s, 13, 1'b0);
    st_got = 1'b0; st_n = 0;
    while (!st_got && st_n < 3000) begin
      @(negedge iclk); st_n++;
      if (odval && oidx == 7'd50) st_got = 1'b1;
    end
    check_val("reach_idx50", 32'(st_got), 32'd1);
    @(posedge iclk); #1;
    ireset = 1'b1;
    exp_q.delete();
    @(posedge iclk);
    @(negedge iclk);
    check_val("midrst_oready", 32'(oready), 32'd1);
    check_val("midrst_odval",  32'(odval),  32'd0);
    check_val("midrst_olast",  32'(olast),  32'd0);
    check_val("midrst_oidx",   32'(oidx),   32'd0);
    check_val("midrst_state",  32'(odbg_state), 32'(ST_IDLE));
    @(posedge iclk); #1;
    ireset = 1'b0;
    repeat (20) @(posedge iclk);

    // Fresh descriptor after reset restarts at oidx 0
    rand_desc(d, s);
    start_desc(d, s, 13, 1'b0);
    wait_done(3000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
